// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_e         loader FSM states
//   HDR_LEN_WIDTH   width of the big-endian image-length header
//   bytes_per_word  number of stream bytes that make one memory word
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StCollect,
        StWrite,
        StDone,
        StError
    } state_e;

    localparam int unsigned HDR_LEN_WIDTH = 16;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into DATA_WIDTH-bit words, first byte in the most
// significant position.
//   clk, reset  clock and synchronous active-high reset
//   shiftEn     shift byteIn into the word this cycle
//   clear       drop any partial word and restart the byte index
//   byteIn      incoming byte
//   word        current contents of the shift register
//   wordFull    high in the cycle the last byte of a word is shifted in
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shiftEn,
    input  logic                  clear,
    input  logic [7:0]            byteIn,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  wordFull
);

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int unsigned IDX_WIDTH = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES_PER_WORD - 1);

    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;

    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        wordFull = 1'b0;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shiftEn) begin
            // Truncation drops the oldest byte off the top, so a full word
            // leaves the first byte in the MSBs.
            word_d   = DATA_WIDTH'({word_q, byteIn});
            wordFull = (idx_q == LAST_IDX);
            idx_d    = wordFull ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a program image from a byte source into instruction memory.
// Stream format: 16-bit big-endian word count L, then L words MSB-first.
//   clk, reset        clock and synchronous active-high reset
//   start             one-cycle pulse that begins a load (IDLE/DONE/ERROR only)
//   byteIn/byteValid  byte stream input; byteReady is the accept side
//   memAddr/memDataIn/memWEn  instruction-memory write port
//   cpuHold           holds the CPU in reset while loading or after an error
//   done / error      level status of the last load
//   wordCount         words written in the current or last load
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DEPTH         = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               byteIn,
    input  logic                     byteValid,
    output logic                     byteReady,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0]    memDataIn,
    output logic                     memWEn,
    output logic                     cpuHold,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH:0]   wordCount
);

    localparam logic [HDR_LEN_WIDTH:0] DEPTH_EXT = (HDR_LEN_WIDTH + 1)'(DEPTH);

    state_e                   state_q, state_d;
    logic [HDR_LEN_WIDTH-1:0] len_q, len_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   count_q, count_d;

    logic                     accept;
    logic [HDR_LEN_WIDTH-1:0] hdr_len;
    logic                     asm_shift;
    logic                     asm_clear;
    logic                     asm_full;
    logic [DATA_WIDTH-1:0]    asm_word;

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clk      (clk),
        .reset    (reset),
        .shiftEn  (asm_shift),
        .clear    (asm_clear),
        .byteIn   (byteIn),
        .word     (asm_word),
        .wordFull (asm_full)
    );

    // Decoded from the state register only, never from byteValid.
    assign byteReady = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StCollect);
    assign accept    = byteValid && byteReady;
    assign hdr_len   = {len_q[HDR_LEN_WIDTH-1:8], byteIn};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        count_d   = count_q;
        asm_shift = 1'b0;
        asm_clear = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    addr_d    = '0;
                    count_d   = '0;
                    asm_clear = 1'b1;
                    state_d   = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    len_d   = {byteIn, len_q[7:0]};
                    state_d = StHdrLo;
                end
            end
            StHdrLo: begin
                if (accept) begin
                    len_d = hdr_len;
                    if (hdr_len == '0) begin
                        state_d = StDone;
                    end else if ({1'b0, hdr_len} > DEPTH_EXT) begin
                        state_d = StError;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                asm_shift = accept;
                if (asm_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Address wraps to 0 after a DEPTH-word image; DONE stops further writes.
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (32'(count_d) == 32'(len_q)) begin
                    state_d = StDone;
                end else begin
                    state_d = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign memWEn    = (state_q == StWrite);
    assign memAddr   = addr_q;
    assign memDataIn = asm_word;
    assign wordCount = count_q;
    assign cpuHold   = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign error     = (state_q == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default parameters).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic [11:0] memAddr;
    logic [31:0] memDataIn;
    logic        memWEn;
    logic        cpuHold;
    logic        done;
    logic        error;
    logic [12:0] wordCount;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .byteIn    (byteIn),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .memAddr   (memAddr),
        .memDataIn (memDataIn),
        .memWEn    (memWEn),
        .cpuHold   (cpuHold),
        .done      (done),
        .error     (error),
        .wordCount (wordCount)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [0:4095];
    int          wr_count = 0;
    logic [11:0] last_addr = '0;
    logic        prev_wen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model plus write-port protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (memWEn) begin
            check_eq("wen_single_cycle", {31'b0, prev_wen}, 32'd0);
            check_eq("ready_in_write", {31'b0, byteReady}, 32'd0);
            mem[memAddr] = memDataIn;
            wr_count++;
            last_addr = memAddr;
        end
        prev_wen = memWEn;
    end

    function automatic logic [7:0] pat(input int k, input int seed);
        return 8'((k * 13 + seed + (k >> 8)) & 255);
    endfunction

    function automatic logic [31:0] word_exp(input int w, input int seed);
        return {pat(4 * w, seed), pat(4 * w + 1, seed), pat(4 * w + 2, seed), pat(4 * w + 3, seed)};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byteIn    = b;
        byteValid = 1'b1;
        while (!byteReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("byte_accept", {31'b0, byteReady}, 32'd1);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic send_image(input int n_words, input int seed, input int max_gap);
        for (int k = 0; k < 4 * n_words; k++) begin
            send_byte(pat(k, seed));
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while (!done && !error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("end_reached", {31'b0, done | error}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        byteValid = 1'b0;
        byteIn    = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_byteReady", {31'b0, byteReady}, 32'd0);
        check_eq("rst_memWEn", {31'b0, memWEn}, 32'd0);
        check_eq("rst_cpuHold", {31'b0, cpuHold}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_error", {31'b0, error}, 32'd0);
        check_eq("rst_memAddr", 32'(memAddr), 32'd0);
        check_eq("rst_memDataIn", memDataIn, 32'd0);
        check_eq("rst_wordCount", 32'(wordCount), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two-word image
        wr_count = 0;
        pulse_start();
        check_eq("hdr_cpuHold", {31'b0, cpuHold}, 32'd1);
        check_eq("hdr_byteReady", {31'b0, byteReady}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        wait_end();
        check_eq("t1_mem0", mem[0], 32'h12345678);
        check_eq("t1_mem1", mem[1], 32'h9ABCDEF0);
        check_eq("t1_writes", 32'(wr_count), 32'd2);
        check_eq("t1_done", {31'b0, done}, 32'd1);
        check_eq("t1_cpuHold", {31'b0, cpuHold}, 32'd0);
        check_eq("t1_wordCount", 32'(wordCount), 32'd2);
        check_eq("t1_memAddr", 32'(memAddr), 32'd2);

        // Zero-length header
        wr_count = 0;
        pulse_start();
        check_eq("t2_done_cleared", {31'b0, done}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        check_eq("t2_done", {31'b0, done}, 32'd1);
        check_eq("t2_cpuHold", {31'b0, cpuHold}, 32'd0);
        check_eq("t2_wordCount", 32'(wordCount), 32'd0);
        check_eq("t2_writes", 32'(wr_count), 32'd0);

        // Oversized header, then recovery
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h01);
        check_eq("t3_error", {31'b0, error}, 32'd1);
        check_eq("t3_cpuHold", {31'b0, cpuHold}, 32'd1);
        check_eq("t3_done", {31'b0, done}, 32'd0);
        check_eq("t3_byteReady", {31'b0, byteReady}, 32'd0);
        check_eq("t3_writes", 32'(wr_count), 32'd0);
        pulse_start();
        check_eq("t3_error_cleared", {31'b0, error}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        wait_end();
        check_eq("t3_done_recover", {31'b0, done}, 32'd1);
        check_eq("t3_mem0", mem[0], 32'hAABBCCDD);
        check_eq("t3_wordCount", 32'(wordCount), 32'd1);

        // 16 words with random stalls
        wr_count = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h10);
        send_image(16, 5, 5);
        wait_end();
        for (int w = 0; w < 16; w++) check_eq("t4_mem", mem[w], word_exp(w, 5));
        check_eq("t4_wordCount", 32'(wordCount), 32'd16);
        check_eq("t4_writes", 32'(wr_count), 32'd16);

        // Reset during the third byte of word 5
        wr_count = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h08);
        for (int k = 0; k < 22; k++) send_byte(pat(k, 99));
        byteIn    = pat(22, 99);
        byteValid = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        check_eq("t5_memWEn", {31'b0, memWEn}, 32'd0);
        check_eq("t5_cpuHold", {31'b0, cpuHold}, 32'd0);
        check_eq("t5_byteReady", {31'b0, byteReady}, 32'd0);
        check_eq("t5_done", {31'b0, done}, 32'd0);
        check_eq("t5_wordCount", 32'(wordCount), 32'd0);
        check_eq("t5_memAddr", 32'(memAddr), 32'd0);
        check_eq("t5_memDataIn", memDataIn, 32'd0);
        reset     = 1'b0;
        byteValid = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 5; w++) check_eq("t5_mem_kept", mem[w], word_exp(w, 99));
        check_eq("t5_writes", 32'(wr_count), 32'd5);

        // Full-depth image
        wr_count = 0;
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h00);
        send_image(4096, 7, 0);
        wait_end();
        check_eq("t6_done", {31'b0, done}, 32'd1);
        check_eq("t6_last_addr", 32'(last_addr), 32'hFFF);
        check_eq("t6_wordCount", 32'(wordCount), 32'd4096);
        check_eq("t6_memAddr_wrap", 32'(memAddr), 32'd0);
        check_eq("t6_writes", 32'(wr_count), 32'd4096);
        check_eq("t6_mem_first", mem[0], word_exp(0, 7));
        check_eq("t6_mem_mid", mem[2048], word_exp(2048, 7));
        check_eq("t6_mem_last", mem[4095], word_exp(4095, 7));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
